eva_ahb_slv_regs: RTL and testbench

- AHB-Lite slave register file: the responder end of the EVA AHB bus path, answering transfers driven by the EVA bus-functional initiator.
- Holds NREG 32-bit registers; register 0 is a read-only ID.
- Inserts a programmable number of wait states per transfer.
- Returns the two-cycle ERROR response for illegal accesses.
- Used as the DUT-side register target for bring-up and as a loopback target for the EVA software flow.

---
 rtl/eva_ahb_slv_regs.sv | 115 +++++++++++
 tb/tb_eva_ahb_slv_regs.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eva_ahb_slv_regs.sv
// eva_ahb_slv_regs: AHB-Lite slave register file with programmable wait states and a read-only ID in reg 0.
// Define EVA_AHB_SLV_ERR_EN to answer illegal accesses with the two-cycle ERROR response.
module eva_ahb_slv_regs #(
  parameter int          NREG     = 16,
  parameter int          WAIT_CYC = 0,
  parameter logic [31:0] ID_VAL   = 32'hE0A0_0001
) (
  input  logic        hclk,
  input  logic        hrest,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);
  localparam int IW = $clog2(NREG);

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [IW-1:0] idx;
  } req_t;

`ifdef EVA_AHB_SLV_ERR_EN
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t      state_q, state_d;
  req_t        req_q, req_d, req_in;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] regs [NREG];
  logic        accept, illegal, commit;
  logic        unused_busy;

  // htrans[0] only separates BUSY from IDLE and SEQ from NONSEQ; neither matters here
  assign unused_busy = htrans[0];

  assign accept  = hsel & htrans[1] & hready_in;
  assign illegal = (hsize != 3'b010) || (haddr[1:0] != 2'b00) ||
                   (haddr[31:2] >= 30'(NREG)) || (hwrite && (haddr[31:2] == 30'd0));
  assign req_in  = '{wr: hwrite, err: illegal, idx: haddr[IW+1:2]};

  always_comb begin
    hready_out = 1'b1;
    hresp      = 2'b00;
    case (state_q)
      DATA: hready_out = (cnt_q == 3'd0);
`ifdef EVA_AHB_SLV_ERR_EN
      ERR1: begin
        hready_out = 1'b0;
        hresp      = 2'b01;
      end
      ERR2: hresp = 2'b01;
`endif
      default: ;
    endcase
  end

  // hready_out high marks the last cycle of any data phase, so it also gates the next address phase
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    if (hready_out) begin
      if (accept) begin
        req_d = req_in;
        cnt_d = 3'(WAIT_CYC);
`ifdef EVA_AHB_SLV_ERR_EN
        state_d = illegal ? ERR1 : DATA;
`else
        state_d = DATA;
`endif
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == DATA) begin
      cnt_d = cnt_q - 3'd1;
    end
`ifdef EVA_AHB_SLV_ERR_EN
    else begin
      state_d = ERR2;
    end
`endif
  end

  assign commit = (state_q == DATA) && hready_out && req_q.wr && !req_q.err;

  always_ff @(posedge hclk) begin
    if (hrest) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= 3'd0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      if (commit) regs[req_q.idx] <= hwdata;
    end
  end

  // err guard also keeps out-of-range indices away from the array
  always_comb begin
    hrdata = '0;
    if ((state_q == DATA) && !req_q.wr && !req_q.err)
      hrdata = (req_q.idx == '0) ? ID_VAL : regs[req_q.idx];
  end
endmodule

// File: tb/tb_eva_ahb_slv_regs.sv
// tb_eva_ahb_slv_regs: directed and random AHB transfers checked against a transaction-level register model.
module tb_eva_ahb_slv_regs;
  localparam int          NREG = 16;
  localparam int          WAIT = 2;
  localparam logic [31:0] ID   = 32'hE0A0_0001;
  localparam int          MAXT = 128;
`ifdef EVA_AHB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hrest, hsel, hwrite, hready_in, hready_out;
  logic [1:0]  htrans, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize;
  bit          gate;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int          len;
    logic [1:0]  resp_first, resp_last;
    logic [31:0] rdata_first, rdata_last;
  } obs_t;

  txn_t        tx  [MAXT];
  obs_t        obs [MAXT];
  int          ntx;
  logic [31:0] mdl [NREG];

  always #5 hclk = ~hclk;
  assign hready_in = gate ? 1'b0 : hready_out;

  eva_ahb_slv_regs #(.NREG(NREG), .WAIT_CYC(WAIT), .ID_VAL(ID)) dut (
    .hclk(hclk), .hrest(hrest), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata)
  );

  function automatic void add(bit wr, logic [31:0] a, logic [2:0] s, logic [31:0] d);
    tx[ntx] = '{wr, a, s, d};
    ntx++;
  endfunction

  // Sequential register-file semantics: a pipelined bus must look like transfers applied in order.
  function automatic void model_step(input txn_t t, output int len, output logic [1:0] resp,
                                     output logic [31:0] rdata);
    int unsigned w;
    bit legal, errp;
    w     = t.addr >> 2;
    legal = (t.size == 3'b010) && (t.addr % 4 == 0) && (w < NREG) && !(t.wr && w == 0);
    errp  = !legal && ERR_EN;
    len   = errp ? 2 : WAIT + 1;
    resp  = errp ? 2'b01 : 2'b00;
    rdata = 32'h0;
    if (legal && !t.wr) rdata = (w == 0) ? ID : mdl[w];
    if (legal && t.wr) mdl[w] = t.data;
  endfunction

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = $urandom; hsize = 3'b010;
  endtask

  task automatic drive_addr(input txn_t t);
    hsel = 1'b1; htrans = 2'b10; hwrite = t.wr; haddr = t.addr; hsize = t.size;
  endtask

  // Drives tx[0..ntx-1] fully pipelined and records what each data phase looked like.
  task automatic run_seq();
    int ai = 0, di = -1, k = 0, guard = 0;
    logic rdy;
    for (int i = 0; i < ntx; i++) obs[i] = '{-1, 2'bxx, 2'bxx, 'x, 'x};
    drive_addr(tx[0]);
    while (guard < 12 * ntx + 20) begin
      guard++;
      @(negedge hclk);
      if (di >= 0) begin
        if (k == 0) begin obs[di].resp_first = hresp; obs[di].rdata_first = hrdata; end
        obs[di].resp_last = hresp; obs[di].rdata_last = hrdata;
      end
      rdy = hready_out;
      @(posedge hclk); #1;
      if (di >= 0) k++;
      if (rdy === 1'b1) begin
        if (di >= 0) obs[di].len = k;
        if (ai >= ntx) break;
        di = ai; ai++; k = 0;
        hwdata = tx[di].data;
        if (ai < ntx) drive_addr(tx[ai]); else drive_idle();
      end
    end
    drive_idle();
    hwdata = $urandom;
  endtask

  task automatic test_reset();
    hrest = 1'b1;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL reset hready_out: got %b expected 1", hready_out); end
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL reset hresp: got %b expected 00", hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset hrdata: got %h expected 0", hrdata); end
    @(posedge hclk); #1;
    hrest = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
  endtask

  task automatic test_id_read();
    int el; logic [1:0] er; logic [31:0] ed;
    ntx = 0;
    add(1'b0, 32'h0, 3'b010, 32'h0);
    add(1'b0, 32'h8, 3'b010, 32'h0);
    run_seq();
    for (int i = 0; i < ntx; i++) begin
      model_step(tx[i], el, er, ed);
      checks++; if (obs[i].len !== el) begin errors++; $display("FAIL id_read[%0d] len: got %0d expected %0d", i, obs[i].len, el); end
      checks++; if ({obs[i].resp_first, obs[i].resp_last} !== {er, er}) begin errors++; $display("FAIL id_read[%0d] hresp: got %b/%b expected %b", i, obs[i].resp_first, obs[i].resp_last, er); end
      checks++; if ({obs[i].rdata_first, obs[i].rdata_last} !== {ed, ed}) begin errors++; $display("FAIL id_read[%0d] hrdata: got %h/%h expected %h", i, obs[i].rdata_first, obs[i].rdata_last, ed); end
    end
  endtask

  task automatic test_back_to_back();
    int el; logic [1:0] er; logic [31:0] ed;
    ntx = 0;
    add(1'b1, 32'h4, 3'b010, 32'h1234_5678);
    add(1'b0, 32'h4, 3'b010, 32'h0);
    add(1'b1, 32'h3C, 3'b010, 32'hA5A5_C3C3);
    add(1'b1, 32'h4, 3'b010, 32'h0BAD_F00D);
    add(1'b0, 32'h4, 3'b010, 32'h0);
    add(1'b0, 32'h3C, 3'b010, 32'h0);
    run_seq();
    for (int i = 0; i < ntx; i++) begin
      model_step(tx[i], el, er, ed);
      checks++; if (obs[i].len !== el) begin errors++; $display("FAIL b2b[%0d] len: got %0d expected %0d", i, obs[i].len, el); end
      checks++; if ({obs[i].resp_first, obs[i].resp_last} !== {er, er}) begin errors++; $display("FAIL b2b[%0d] hresp: got %b/%b expected %b", i, obs[i].resp_first, obs[i].resp_last, er); end
      checks++; if ({obs[i].rdata_first, obs[i].rdata_last} !== {ed, ed}) begin errors++; $display("FAIL b2b[%0d] hrdata: got %h/%h expected %h", i, obs[i].rdata_first, obs[i].rdata_last, ed); end
    end
  endtask

  task automatic test_errors();
    int el; logic [1:0] er; logic [31:0] ed;
    ntx = 0;
    add(1'b1, 32'h8, 3'b010, 32'h5555_AAAA);
    add(1'b0, 32'h40, 3'b010, 32'h0);
    add(1'b1, 32'h8, 3'b000, 32'h1111_1111);
    add(1'b1, 32'h6, 3'b010, 32'h2222_2222);
    add(1'b1, 32'h0, 3'b010, 32'h3333_3333);
    add(1'b0, 32'h2, 3'b010, 32'h0);
    add(1'b0, 32'h8, 3'b001, 32'h0);
    add(1'b0, 32'h8, 3'b010, 32'h0);
    add(1'b0, 32'h4, 3'b010, 32'h0);
    add(1'b0, 32'h0, 3'b010, 32'h0);
    run_seq();
    for (int i = 0; i < ntx; i++) begin
      model_step(tx[i], el, er, ed);
      checks++; if (obs[i].len !== el) begin errors++; $display("FAIL err[%0d] len: got %0d expected %0d", i, obs[i].len, el); end
      checks++; if ({obs[i].resp_first, obs[i].resp_last} !== {er, er}) begin errors++; $display("FAIL err[%0d] hresp: got %b/%b expected %b", i, obs[i].resp_first, obs[i].resp_last, er); end
      checks++; if ({obs[i].rdata_first, obs[i].rdata_last} !== {ed, ed}) begin errors++; $display("FAIL err[%0d] hrdata: got %h/%h expected %h", i, obs[i].rdata_first, obs[i].rdata_last, ed); end
    end
  endtask

  task automatic test_gating();
    int el; logic [1:0] er; logic [31:0] ed;
    for (int c = 0; c < 6; c++) begin
      hwrite = 1'b1; haddr = 32'h8; hsize = 3'b010; hwdata = $urandom;
      case (c)
        0, 1: begin hsel = 1'b0; htrans = 2'b10; gate = 1'b0; end
        2:    begin hsel = 1'b1; htrans = 2'b00; gate = 1'b0; end
        3:    begin hsel = 1'b1; htrans = 2'b01; gate = 1'b0; end
        default: begin hsel = 1'b1; htrans = 2'b10; gate = 1'b1; end
      endcase
      @(negedge hclk);
      checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL gating[%0d] hready_out: got %b expected 1", c, hready_out); end
      checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL gating[%0d] hresp: got %b expected 00", c, hresp); end
      @(posedge hclk); #1;
    end
    gate = 1'b0;
    drive_idle();
    ntx = 0;
    add(1'b0, 32'h8, 3'b010, 32'h0);
    run_seq();
    model_step(tx[0], el, er, ed);
    checks++; if (obs[0].rdata_last !== ed) begin errors++; $display("FAIL gating readback: got %h expected %h", obs[0].rdata_last, ed); end
  endtask

  task automatic test_random();
    int el; logic [1:0] er; logic [31:0] ed;
    int r;
    ntx = 0;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       add(1'($urandom), 32'($urandom_range(0, NREG - 1)) << 2, 3'b010, $urandom);
      else if (r == 7) add(1'($urandom), 32'($urandom_range(0, 4 * NREG + 15)), 3'b010, $urandom);
      else if (r == 8) add(1'($urandom), 32'($urandom_range(NREG, NREG + 7)) << 2, 3'b010, $urandom);
      else             add(1'($urandom), 32'($urandom_range(0, NREG - 1)) << 2, 3'($urandom), $urandom);
    end
    run_seq();
    for (int i = 0; i < ntx; i++) begin
      model_step(tx[i], el, er, ed);
      checks++; if (obs[i].len !== el) begin errors++; $display("FAIL rand[%0d] len: got %0d expected %0d", i, obs[i].len, el); end
      checks++; if ({obs[i].resp_first, obs[i].resp_last} !== {er, er}) begin errors++; $display("FAIL rand[%0d] hresp: got %b/%b expected %b", i, obs[i].resp_first, obs[i].resp_last, er); end
      checks++; if ({obs[i].rdata_first, obs[i].rdata_last} !== {ed, ed}) begin errors++; $display("FAIL rand[%0d] hrdata: got %h/%h expected %h", i, obs[i].rdata_first, obs[i].rdata_last, ed); end
    end
  endtask

  task automatic test_reset_mid_write();
    int el; logic [1:0] er; logic [31:0] ed;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8; hsize = 3'b010;
    @(posedge hclk); #1;
    drive_idle();
    hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    checks++; if (hready_out !== 1'b0) begin errors++; $display("FAIL rst_mid wait hready_out: got %b expected 0", hready_out); end
    @(posedge hclk); #1;
    hrest = 1'b1;
    @(posedge hclk); #1;
    hrest = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge hclk);
      checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL rst_mid[%0d] hready_out: got %b expected 1", c, hready_out); end
      checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL rst_mid[%0d] hresp: got %b expected 00", c, hresp); end
      @(posedge hclk); #1;
    end
    ntx = 0;
    add(1'b0, 32'h8, 3'b010, 32'h0);
    add(1'b0, 32'h4, 3'b010, 32'h0);
    run_seq();
    for (int i = 0; i < ntx; i++) begin
      model_step(tx[i], el, er, ed);
      checks++; if (obs[i].rdata_last !== ed) begin errors++; $display("FAIL rst_mid readback[%0d]: got %h expected %h", i, obs[i].rdata_last, ed); end
    end
  endtask

  initial begin
    hrest = 1'b1; gate = 1'b0; hwdata = 32'h0;
    drive_idle();
    test_reset();
    test_id_read();
    test_back_to_back();
    test_errors();
    test_gating();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
